// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the restoring divider and its
// carry-lookahead subtractor.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int CLA_WIDTH    = 4;
  localparam int DIV_MAX_BITS = 64;

  // All-ones quotient reported for a zero divisor, truncated by the caller.
  function automatic logic [DIV_MAX_BITS-1:0] dbz_quotient(input int width);
    logic [DIV_MAX_BITS-1:0] mask_v;
    mask_v = '0;
    for (int i = 0; i < DIV_MAX_BITS; i++) begin
      if (i < width) begin
        mask_v[i] = 1'b1;
      end else begin
        mask_v[i] = 1'b0;
      end
    end
    return mask_v;
  endfunction

  // 4-bit carry-lookahead add; returns {c_out, sum}.
  function automatic logic [CLA_WIDTH:0] cla4_add(input logic [3:0] a,
                                                   input logic [3:0] b,
                                                   input logic       c_in);
    logic [3:0] g_v;
    logic [3:0] p_v;
    logic [4:0] c_v;
    g_v    = a & b;
    p_v    = a ^ b;
    c_v[0] = c_in;
    c_v[1] = g_v[0] | (p_v[0] & c_in);
    c_v[2] = g_v[1] | (p_v[1] & g_v[0]) | (p_v[1] & p_v[0] & c_in);
    c_v[3] = g_v[2] | (p_v[2] & g_v[1]) | (p_v[2] & p_v[1] & g_v[0])
           | (p_v[2] & p_v[1] & p_v[0] & c_in);
    c_v[4] = g_v[3] | (p_v[3] & g_v[2]) | (p_v[3] & p_v[2] & g_v[1])
           | (p_v[3] & p_v[2] & p_v[1] & g_v[0])
           | (p_v[3] & p_v[2] & p_v[1] & p_v[0] & c_in);
    return {c_v[4], p_v ^ c_v[3:0]};
  endfunction

endpackage

// File: rtl/nbit_cla_subtractor.sv
// a - b as a + ~b + 1 through a ripple of 4-bit carry-lookahead blocks;
// c_out is the inverted borrow.
module nbit_cla_subtractor
  import div_pkg::*;
#(
  parameter int NUMBITS = 8
) (
  input  logic [NUMBITS-1:0] a,
  input  logic [NUMBITS-1:0] b,
  output logic [NUMBITS-1:0] diff,
  output logic               c_out
);

  localparam int NBLK = NUMBITS / CLA_WIDTH;

  logic [NBLK:0]        carry_s;
  logic [NUMBITS-1:0]   b_inv_s;

  assign b_inv_s    = ~b;
  assign carry_s[0] = 1'b1;

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    logic [CLA_WIDTH:0] res_s;
    assign res_s                        = cla4_add(a[i*CLA_WIDTH +: CLA_WIDTH],
                                                   b_inv_s[i*CLA_WIDTH +: CLA_WIDTH],
                                                   carry_s[i]);
    assign diff[i*CLA_WIDTH +: CLA_WIDTH] = res_s[CLA_WIDTH-1:0];
    assign carry_s[i+1]                 = res_s[CLA_WIDTH];
  end

  assign c_out = carry_s[NBLK];

endmodule

// File: rtl/nbit_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, with
// valid/ready handshakes on the operand and result sides.
module nbit_restoring_divider
  import div_pkg::*;
#(
  parameter int NUMBITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] dividend_in,
  input  logic [NUMBITS-1:0] divisor_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] quotient_out,
  output logic [NUMBITS-1:0] remainder_out,
  output logic               div_by_zero_out
);

  if ((NUMBITS <= 0) || ((NUMBITS % CLA_WIDTH) != 0) || (NUMBITS > DIV_MAX_BITS)) begin : g_bad_width
    $error("nbit_restoring_divider: NUMBITS must be a non-zero multiple of 4 (max 64)");
  end

  localparam int                      CNT_W     = (NUMBITS > 1) ? $clog2(NUMBITS) : 1;
  localparam logic [CNT_W-1:0]        LAST_STEP = CNT_W'(NUMBITS - 1);
  localparam logic [DIV_MAX_BITS-1:0] DBZ_FULL  = dbz_quotient(NUMBITS);
  localparam logic [NUMBITS-1:0]      DBZ_Q     = DBZ_FULL[NUMBITS-1:0];

  div_state_e         state_r, next_state_s;
  logic [NUMBITS-1:0] d_r, q_r, r_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               in_ready_r, out_valid_r, dbz_r;
  logic [NUMBITS-1:0] quotient_r, remainder_r;

  logic [NUMBITS-1:0] s_low_s, t_s, r_next_s, q_next_s;
  logic               m_s, c_out_s, success_s, last_step_s;

  // The shifted-out top bit m means S >= 2^NUMBITS > D, so subtraction must win.
  assign s_low_s     = {r_r[NUMBITS-2:0], q_r[NUMBITS-1]};
  assign m_s         = r_r[NUMBITS-1];
  assign success_s   = m_s | c_out_s;
  assign r_next_s    = success_s ? t_s : s_low_s;
  assign q_next_s    = {q_r[NUMBITS-2:0], success_s};
  assign last_step_s = (cnt_r == LAST_STEP);

  nbit_cla_subtractor #(.NUMBITS(NUMBITS)) u_sub (
    .a     (s_low_s),
    .b     (d_r),
    .diff  (t_s),
    .c_out (c_out_s)
  );

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          next_state_s = (divisor_in == '0) ? DONE : CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (last_step_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake/result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      d_r         <= '0;
      q_r         <= '0;
      r_r         <= '0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      dbz_r       <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == IDLE);
      out_valid_r <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            d_r   <= divisor_in;
            cnt_r <= '0;
            if (divisor_in == '0) begin
              q_r         <= DBZ_Q;
              r_r         <= dividend_in;
              quotient_r  <= DBZ_Q;
              remainder_r <= dividend_in;
              dbz_r       <= 1'b1;
            end else begin
              q_r   <= dividend_in;
              r_r   <= '0;
              dbz_r <= 1'b0;
            end
          end
        end
        CALC: begin
          q_r <= q_next_s;
          r_r <= r_next_s;
          if (last_step_s) begin
            cnt_r       <= '0;
            quotient_r  <= q_next_s;
            remainder_r <= r_next_s;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready        = in_ready_r;
  assign out_valid       = out_valid_r;
  assign quotient_out    = quotient_r;
  assign remainder_out   = remainder_r;
  assign div_by_zero_out = dbz_r;

endmodule

// File: tb/tb_nbit_restoring_divider.sv
// Self-checking bench: 8- and 16-bit dividers against a plain-arithmetic
// model, directed vectors with literal expectations, reset abort and random pairs.
module tb_nbit_restoring_divider;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       iv8 = 1'b0, ir8, ov8, ordy8 = 1'b0, z8;
  logic [7:0] a8 = 8'd0, b8 = 8'd0, q8, r8;
  logic        iv16 = 1'b0, ir16, ov16, ordy16 = 1'b0, z16;
  logic [15:0] a16 = 16'd0, b16 = 16'd0, q16, r16;

  nbit_restoring_divider #(.NUMBITS(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .dividend_in(a8), .divisor_in(b8), .out_valid(ov8), .out_ready(ordy8),
    .quotient_out(q8), .remainder_out(r8), .div_by_zero_out(z8)
  );

  nbit_restoring_divider #(.NUMBITS(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
    .dividend_in(a16), .divisor_in(b16), .out_valid(ov16), .out_ready(ordy16),
    .quotient_out(q16), .remainder_out(r16), .div_by_zero_out(z16)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int          sel_w = 8;
  logic        exp_active = 1'b0;
  logic [15:0] exp_a = 16'd0, exp_b = 16'd0, exp_q = 16'd0, exp_r = 16'd0;
  logic        exp_z = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [15:0] width_mask(input int w);
    return (w == 16) ? 16'hFFFF : 16'h00FF;
  endfunction

  // Model: plain integer division; zero divisor gives all-ones and the dividend.
  task automatic set_expect(input int w, input logic [15:0] a, input logic [15:0] b);
    sel_w = w;
    exp_a = a;
    exp_b = b;
    if (b == 16'd0) begin
      exp_q = width_mask(w);
      exp_r = a;
      exp_z = 1'b1;
    end else begin
      exp_q = a / b;
      exp_r = a % b;
      exp_z = 1'b0;
    end
  endtask

  task automatic drive(input int w, input logic v, input logic [15:0] a, input logic [15:0] b);
    if (w == 8) begin
      iv8 = v; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      iv16 = v; a16 = a; b16 = b;
    end
  endtask

  task automatic set_ordy(input int w, input logic v);
    if (w == 8) ordy8 = v;
    else ordy16 = v;
  endtask

  task automatic sample(input int w, output logic rdy, output logic vld,
                        output logic [15:0] q, output logic [15:0] r, output logic z);
    if (w == 8) begin
      rdy = ir8; vld = ov8; q = {8'd0, q8}; r = {8'd0, r8}; z = z8;
    end else begin
      rdy = ir16; vld = ov16; q = q16; r = r16; z = z16;
    end
  endtask

  // Compare process: handshake exclusivity every cycle, results whenever presented.
  always @(negedge clk) begin : compare
    logic        rdy, vld, z;
    logic [15:0] q, r;
    logic [31:0] recon;
    check("no_overlap8", {31'd0, ir8 & ov8}, 32'd0);
    check("no_overlap16", {31'd0, ir16 & ov16}, 32'd0);
    sample(sel_w, rdy, vld, q, r, z);
    if (exp_active && vld) begin
      check("model_quotient", {16'd0, q}, {16'd0, exp_q});
      check("model_remainder", {16'd0, r}, {16'd0, exp_r});
      check("model_dbz", {31'd0, z}, {31'd0, exp_z});
      if (!exp_z) begin
        recon = ({16'd0, q} * {16'd0, exp_b}) + {16'd0, r};
        check("invariant_qd_plus_r", recon, {16'd0, exp_a});
        check("invariant_r_lt_d", {31'd0, (r < exp_b)}, 32'd1);
      end
    end
  end

  task automatic start_div(input int w, input logic [15:0] a, input logic [15:0] b);
    logic        rdy, vld, z;
    logic [15:0] q, r;
    int          k;
    set_expect(w, a, b);
    exp_active = 1'b1;
    k = 0;
    @(negedge clk);
    sample(w, rdy, vld, q, r, z);
    while (!rdy && k < 50) begin
      @(negedge clk);
      sample(w, rdy, vld, q, r, z);
      k++;
    end
    check("in_ready_before_accept", {31'd0, rdy}, 32'd1);
    drive(w, 1'b1, a, b);
    @(posedge clk);
    #1 drive(w, 1'b0, ~a, ~b);
  endtask

  task automatic finish_div(input int w, input int stall,
                            output logic [15:0] q_cap, output logic [15:0] r_cap, output logic z_cap);
    logic        rdy, vld, z;
    logic [15:0] q, r;
    int          lat;
    lat = 0;
    @(negedge clk);
    sample(w, rdy, vld, q, r, z);
    while (!vld && lat < 40) begin
      @(negedge clk);
      sample(w, rdy, vld, q, r, z);
      lat++;
    end
    check("latency_edges_after_accept", lat, (exp_b == 16'd0) ? 32'd0 : w);
    q_cap = q; r_cap = r; z_cap = z;
    for (int i = 0; i < stall; i++) begin
      check("in_ready_low_while_done", {31'd0, rdy}, 32'd0);
      drive(w, 1'b1, 16'd7, 16'd1);
      @(negedge clk);
      sample(w, rdy, vld, q, r, z);
      check("held_valid", {31'd0, vld}, 32'd1);
      check("held_quotient", {16'd0, q}, {16'd0, q_cap});
      check("held_remainder", {16'd0, r}, {16'd0, r_cap});
    end
    drive(w, 1'b0, 16'd0, 16'd0);
    set_ordy(w, 1'b1);
    @(posedge clk);
    #1 set_ordy(w, 1'b0);
    exp_active = 1'b0;
    @(negedge clk);
    sample(w, rdy, vld, q, r, z);
    check("in_ready_after_result", {31'd0, rdy}, 32'd1);
    check("out_valid_after_result", {31'd0, vld}, 32'd0);
  endtask

  typedef struct {
    int          w;
    logic [15:0] a, b;
    int          stall;
    logic [15:0] q, r;
    logic        z;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] q, r, a, b;
    logic        z, rdy, vld;
    vecs[0] = '{8,  16'd100,   16'd7,     0, 16'd14,    16'd2,    1'b0};
    vecs[1] = '{8,  16'd255,   16'd200,   0, 16'd1,     16'd55,   1'b0};
    vecs[2] = '{8,  16'd5,     16'd9,     1, 16'd0,     16'd5,    1'b0};
    vecs[3] = '{8,  16'd255,   16'd1,     0, 16'd255,   16'd0,    1'b0};
    vecs[4] = '{8,  16'd42,    16'd0,     0, 16'd255,   16'd42,   1'b1};
    vecs[5] = '{8,  16'd42,    16'd6,     0, 16'd7,     16'd0,    1'b0};
    vecs[6] = '{8,  16'd200,   16'd3,     5, 16'd66,    16'd2,    1'b0};
    vecs[7] = '{16, 16'd60000, 16'd7,     0, 16'd8571,  16'd3,    1'b0};
    vecs[8] = '{16, 16'd65535, 16'd65535, 0, 16'd1,     16'd0,    1'b0};
    vecs[9] = '{16, 16'd1000,  16'd0,     2, 16'd65535, 16'd1000, 1'b1};

    repeat (2) @(negedge clk);
    for (int w = 8; w <= 16; w += 8) begin
      sample(w, rdy, vld, q, r, z);
      check("reset_in_ready", {31'd0, rdy}, 32'd1);
      check("reset_out_valid", {31'd0, vld}, 32'd0);
      check("reset_quotient", {16'd0, q}, 32'd0);
      check("reset_remainder", {16'd0, r}, 32'd0);
      check("reset_dbz", {31'd0, z}, 32'd0);
    end
    reset = 1'b0;

    foreach (vecs[i]) begin
      start_div(vecs[i].w, vecs[i].a, vecs[i].b);
      finish_div(vecs[i].w, vecs[i].stall, q, r, z);
      check("literal_quotient", {16'd0, q}, {16'd0, vecs[i].q});
      check("literal_remainder", {16'd0, r}, {16'd0, vecs[i].r});
      check("literal_dbz", {31'd0, z}, {31'd0, vecs[i].z});
    end

    // Abort 100/7 after four CALC steps; nothing of it may surface.
    start_div(8, 16'd100, 16'd7);
    repeat (4) @(posedge clk);
    exp_active = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("abort_in_ready", {31'd0, ir8}, 32'd1);
    check("abort_out_valid", {31'd0, ov8}, 32'd0);
    check("abort_quotient", {24'd0, q8}, 32'd0);
    check("abort_remainder", {24'd0, r8}, 32'd0);
    check("abort_dbz", {31'd0, z8}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    start_div(8, 16'd9, 16'd2);
    finish_div(8, 0, q, r, z);
    check("after_abort_quotient", {16'd0, q}, 32'd4);
    check("after_abort_remainder", {16'd0, r}, 32'd1);

    for (int w = 8; w <= 16; w += 8) begin
      for (int n = 0; n < 1000; n++) begin
        int pick;
        a    = 16'($urandom) & width_mask(w);
        pick = $urandom_range(0, 15);
        if (pick == 0) b = 16'd0;
        else if (pick < 6) b = 16'($urandom_range(1, 15));
        else b = 16'($urandom) & width_mask(w);
        start_div(w, a, b);
        finish_div(w, $urandom_range(0, 2), q, r, z);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
